// File: rtl/data_mem_pipe.sv
// Single-port data memory with valid/ready request and response channels, byte
// enables, RD_LAT-deep stallable read pipeline and out-of-range error flagging.
// Optional build macro DMEM_FWD_EN adds a one-entry last-write forwarding register.
module data_mem_pipe #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int INIT_IDENTITY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                 input logic [DATA_W-1:0] new_w,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int k = 0; k < BE_W; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

  logic              stall;
  logic              accept;
  logic              in_range;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] words [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] arr_word;
  logic [DATA_W-1:0] rdata_in;

  // A held response freezes the whole pipeline and blocks new requests.
  assign stall     = resp_valid && !resp_ready;
  assign req_ready = !stall;
  assign accept    = req_valid && req_ready;
  assign in_range  = (req_addr < ADDR_W'(DEPTH));
  assign idx       = req_addr[IDX_W-1:0];
  assign wr_en     = accept && req_we && in_range;
  assign rd_word   = words[idx];

  // Storage: each word carries its power-up value; writes commit at acceptance.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DATA_W-1:0] word = (INIT_IDENTITY != 0) ? DATA_W'(i) : '0;

    always_ff @(posedge clk) begin
      if (wr_en && (idx == IDX_W'(i))) word <= merge_be(word, req_wdata, req_be);
    end

    assign words[i] = word;
  end

`ifdef DMEM_FWD_EN
  logic              fwd_vld;
  logic [IDX_W-1:0]  fwd_idx;
  logic [DATA_W-1:0] fwd_word;

  // Last-write register covers read-during-write on synchronous-RAM targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld  <= 1'b0;
      fwd_idx  <= '0;
      fwd_word <= '0;
    end else begin
      fwd_vld <= wr_en;
      if (wr_en) begin
        fwd_idx  <= idx;
        fwd_word <= merge_be(rd_word, req_wdata, req_be);
      end
    end
  end

  assign arr_word = (fwd_vld && (fwd_idx == idx)) ? fwd_word : rd_word;
`else
  assign arr_word = rd_word;
`endif

  assign rdata_in = (req_we || !in_range) ? '0 : arr_word;

  // Response pipeline: stage 0 captures at acceptance, stage RD_LAT-1 drives the outputs.
  logic              vld_p   [RD_LAT];
  logic [DATA_W-1:0] rdata_p [RD_LAT];
  logic              err_p   [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) vld_p[s] <= 1'b0;
    end else if (!stall) begin
      vld_p[0] <= accept;
      for (int s = 1; s < RD_LAT; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      rdata_p[0] <= rdata_in;
      err_p[0]   <= !in_range;
      for (int s = 1; s < RD_LAT; s++) begin
        rdata_p[s] <= rdata_p[s-1];
        err_p[s]   <= err_p[s-1];
      end
    end
  end

  // Output stage: data and error are masked while no response is present.
  assign resp_valid = vld_p[RD_LAT-1];
  assign resp_rdata = resp_valid ? rdata_p[RD_LAT-1] : '0;
  assign resp_err   = resp_valid && err_p[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: a word-array/queue reference model checked every
// cycle, plus literal expectations for each scenario. Works with or without DMEM_FWD_EN.
module tb_data_mem_pipe;
  parameter int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_mem_pipe #(
    .DATA_W(32), .DEPTH(256), .ADDR_W(32), .RD_LAT(RD_LAT), .INIT_IDENTITY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stall = -1;

  logic [31:0] mm [256];
  logic [31:0] exp_data [$];
  logic        exp_err  [$];
  int          exp_cyc  [$];
  bit          front_seen = 1'b0;
  logic [31:0] log_data [$];
  logic        log_err  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model and per-cycle compare, sampled mid-cycle.
  initial begin
    for (int i = 0; i < 256; i++) mm[i] = 32'(i);
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
        exp_data.delete(); exp_err.delete(); exp_cyc.delete();
        front_seen = 1'b0;
      end else begin
        chk("req_ready_rule", 64'(req_ready), 64'(!(resp_valid && !resp_ready)));
        if (resp_valid) begin
          if (exp_data.size() == 0) begin
            chk("unexpected_resp", 64'(resp_rdata), 64'hdead_0000_0000);
          end else begin
            chk("resp_rdata", 64'(resp_rdata), 64'(exp_data[0]));
            chk("resp_err", 64'(resp_err), 64'(exp_err[0]));
            if (!front_seen) begin
              front_seen = 1'b1;
              if (last_stall < exp_cyc[0])
                chk("resp_latency", 64'(cyc - exp_cyc[0]), 64'(RD_LAT));
            end
            if (resp_ready) begin
              log_data.push_back(resp_rdata);
              log_err.push_back(resp_err);
              void'(exp_data.pop_front()); void'(exp_err.pop_front()); void'(exp_cyc.pop_front());
              front_seen = 1'b0;
            end else begin
              last_stall = cyc;
            end
          end
        end else begin
          chk("idle_rdata", 64'(resp_rdata), 64'(0));
        end
        if (req_valid && req_ready) begin
          if (req_addr < 32'd256) begin
            if (req_we) begin
              for (int k = 0; k < 4; k++)
                if (req_be[k]) mm[req_addr][8*k +: 8] = req_wdata[8*k +: 8];
              exp_data.push_back(32'h0);
            end else begin
              exp_data.push_back(mm[req_addr]);
            end
            exp_err.push_back(1'b0);
          end else begin
            exp_data.push_back(32'h0);
            exp_err.push_back(1'b1);
          end
          exp_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    bit done;
    done = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr);
    issue(1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 100 && log_data.size() < n; i++) step(1);
    chk("resp_count", 64'(log_data.size()), 64'(n));
  endtask

  task automatic clear_log();
    log_data.delete(); log_err.delete();
  endtask

  task automatic chk_log(input string name, input int i, input logic [31:0] d, input logic e);
    if (log_data.size() > i) begin
      chk(name, 64'(log_data[i]), 64'(d));
      chk({name, "_err"}, 64'(log_err[i]), 64'(e));
    end else begin
      chk({name, "_missing"}, 64'(log_data.size()), 64'(i + 1));
    end
  endtask

  initial begin
    int n, c0, seen;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_be = '0; resp_ready = 1'b1;
    step(3);
    chk("reset_req_ready", 64'(req_ready), 64'(1));
    chk("reset_resp_valid", 64'(resp_valid), 64'(0));
    rst = 1'b0;
    step(1);

    // 1: identity reads and single-request latency
    clear_log();
    rd(32'h0); rd(32'h0F);
    wait_log(2);
    chk_log("t1_rd_00", 0, 32'h0, 1'b0);
    chk_log("t1_rd_0f", 1, 32'h0000000F, 1'b0);
    rd(32'h0F);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk("t1_latency", 64'(n), 64'(RD_LAT));
    step(2);

    // 2: full-word write then read
    clear_log();
    issue(1'b1, 32'h0, 32'hAAAAAAAA, 4'hF); rd(32'h0);
    wait_log(2);
    chk_log("t2_wr_resp", 0, 32'h0, 1'b0);
    chk_log("t2_rd_00", 1, 32'hAAAAAAAA, 1'b0);

    // 3: partial byte-enable write
    clear_log();
    issue(1'b1, 32'h0F, 32'h12345678, 4'b0101); rd(32'h0F);
    wait_log(2);
    chk_log("t3_rd_0f", 1, 32'h00340078, 1'b0);

    // 4: out of range, no aliasing, boundary address
    clear_log();
    rd(32'h100);
    issue(1'b1, 32'h0, 32'h0, 4'hF);
    issue(1'b1, 32'h100, 32'h55, 4'hF);
    rd(32'h0); rd(32'hFF); rd(32'hFFFFFFFF);
    wait_log(6);
    chk_log("t4_rd_100", 0, 32'h0, 1'b1);
    chk_log("t4_wr_100", 2, 32'h0, 1'b1);
    chk_log("t4_rd_00", 3, 32'h0, 1'b0);
    chk_log("t4_rd_ff", 4, 32'hFF, 1'b0);
    chk_log("t4_rd_max", 5, 32'h0, 1'b1);

    // Write-then-read and read-then-write on consecutive cycles
    clear_log();
    issue(1'b1, 32'h5, 32'hDEADBEEF, 4'b1100); rd(32'h5);
    rd(32'h6); issue(1'b1, 32'h6, 32'h77, 4'hF); rd(32'h6);
    wait_log(5);
    chk_log("raw_fwd_5", 1, 32'hDEAD0005, 1'b0);
    chk_log("war_old_6", 2, 32'h6, 1'b0);
    chk_log("war_new_6", 4, 32'h77, 1'b0);

    // Full throughput with resp_ready held high
    clear_log();
    c0 = cyc;
    for (int i = 0; i < 8; i++) rd(32'h10 + 32'(i));
    chk("throughput_cycles", 64'(cyc - c0), 64'(8));
    wait_log(8);
    for (int i = 0; i < 8; i++) chk_log("tp_rd", i, 32'h10 + 32'(i), 1'b0);

    // 5: stall with three reads outstanding
    clear_log();
    resp_ready = 1'b0;
    fork
      begin
        rd(32'h1); rd(32'h2); rd(32'h3);
      end
      begin
        step(6);
        chk("t5_req_ready_low", 64'(req_ready), 64'(0));
        chk("t5_hold_valid", 64'(resp_valid), 64'(1));
        chk("t5_hold_data", 64'(resp_rdata), 64'h1);
        step(2);
        chk("t5_hold_data_later", 64'(resp_rdata), 64'h1);
        resp_ready = 1'b1;
      end
    join
    wait_log(3);
    chk_log("t5_resp_1", 0, 32'h1, 1'b0);
    chk_log("t5_resp_2", 1, 32'h2, 1'b0);
    chk_log("t5_resp_3", 2, 32'h3, 1'b0);

    // 6: reset with reads in flight
    rd(32'h20); rd(32'h21);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(resp_valid), 64'(0));
    chk("t6_rst_ready", 64'(req_ready), 64'(1));
    chk("t6_rst_rdata", 64'(resp_rdata), 64'(0));
    step(2);
    rst = 1'b0;
    clear_log();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("t6_no_stale", 64'(seen), 64'(0));
    step(1);
    rd(32'h22);
    wait_log(1);
    chk_log("t6_recover", 0, 32'h22, 1'b0);

    for (int i = 0; i < 50 && exp_data.size() != 0; i++) step(1);
    chk("drain_outstanding", 64'(exp_data.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
